// File: rtl/oled_frame_arbiter.sv
// Round-robin arbiter sharing one OLED character-draw port between two
// 4-character frame clients, with busy-handshake timeout supervision.
module oled_frame_arbiter #(
  parameter int FCLK            = 10000,
  parameter int BUSY_TIMEOUT_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReqA,
  input  logic [19:0] iFrameA,
  output logic        oAckA,
  input  logic        iReqB,
  input  logic [19:0] iFrameB,
  output logic        oAckB,
  output logic [1:0]  oPlaceHolder,
  output logic [4:0]  oChar,
  output logic        oDraw,
  input  logic        iBusy,
  output logic        oActive,
  output logic        oOwner,
  output logic        oTimeout
);
  localparam logic [31:0] LIMIT_M1 = 32'(FCLK * BUSY_TIMEOUT_MS) - 32'd1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [19:0] shadow_q, shadow_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  ph_q, ph_d;
  logic [4:0]  char_q, char_d;
  logic        owner_q, owner_d;
  logic        active_q, active_d;
  logic        draw_q, draw_d;
  logic        ackA_q, ackA_d;
  logic        ackB_q, ackB_d;
  logic        tmo_q, tmo_d;
  logic        grant_b;
  logic        abort;

  function automatic logic [4:0] char_sel(input logic [19:0] f, input logic [1:0] i);
    case (i)
      2'd0:    char_sel = f[19:15];
      2'd1:    char_sel = f[14:10];
      2'd2:    char_sel = f[9:5];
      default: char_sel = f[4:0];
    endcase
  endfunction

  // B wins when it requests alone, or on a tie when A was served last.
  assign grant_b = iReqB & (~iReqA | ~owner_q);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    char_d   = char_q;
    owner_d  = owner_q;
    active_d = active_q;
    draw_d   = draw_q;
    ackA_d   = 1'b0;
    ackB_d   = 1'b0;
    tmo_d    = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iReqA | iReqB) begin
          owner_d  = grant_b;
          shadow_d = grant_b ? iFrameB : iFrameA;
          idx_d    = 2'd0;
          active_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ph_d    = idx_q;
        char_d  = char_sel(shadow_q, idx_q);
        draw_d  = 1'b1;
        cnt_d   = 32'd0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        cnt_d = cnt_q + 32'd1;
        if (iBusy) begin
          draw_d  = 1'b0;
          state_d = S_WAIT_LO;
        end else if (cnt_q >= LIMIT_M1) begin
          abort = 1'b1;
        end
      end
      S_WAIT_LO: begin
        cnt_d = cnt_q + 32'd1;
        if (!iBusy) begin
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q >= LIMIT_M1) begin
          abort = 1'b1;
        end
      end
      S_DONE: begin
        ackA_d   = ~owner_q;
        ackB_d   = owner_q;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A hung handshake drops the rest of the frame but still acks the owner.
    if (abort) begin
      draw_d   = 1'b0;
      tmo_d    = 1'b1;
      ackA_d   = ~owner_q;
      ackB_d   = owner_q;
      active_d = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shadow_q <= 20'd0;
      idx_q    <= 2'd0;
      cnt_q    <= 32'd0;
      ph_q     <= 2'd0;
      char_q   <= 5'd0;
      owner_q  <= 1'b1;
      active_q <= 1'b0;
      draw_q   <= 1'b0;
      ackA_q   <= 1'b0;
      ackB_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      char_q   <= char_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      draw_q   <= draw_d;
      ackA_q   <= ackA_d;
      ackB_q   <= ackB_d;
      tmo_q    <= tmo_d;
    end
  end

  assign oAckA        = ackA_q;
  assign oAckB        = ackB_q;
  assign oPlaceHolder = ph_q;
  assign oChar        = char_q;
  assign oDraw        = draw_q;
  assign oActive      = active_q;
  assign oOwner       = owner_q;
  assign oTimeout     = tmo_q;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Randomized bench for oled_frame_arbiter: a frame/handshake-level reference
// model predicts every output each cycle while a random OLED driver answers draws.
module tb_oled_frame_arbiter;
  localparam int FCLK  = 10;
  localparam int BMS   = 2;
  localparam int LIMIT = FCLK * BMS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iReqA = 1'b0, iReqB = 1'b0, iBusy = 1'b0;
  logic [19:0] iFrameA = 20'd0, iFrameB = 20'd0;
  logic        oAckA, oAckB, oDraw, oActive, oOwner, oTimeout;
  logic [1:0]  oPlaceHolder;
  logic [4:0]  oChar;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_owner = 1'b1, m_idle = 1'b1, m_active = 1'b0, m_draw = 1'b0;
  bit          m_in = 1'b0, m_hi = 1'b0, m_due = 1'b0, m_ack_pend = 1'b0;
  int          m_wc = 0;
  logic [1:0]  m_idx = 2'd0, m_ph = 2'd0;
  logic [4:0]  m_chr = 5'd0;
  logic [19:0] m_shadow = 20'd0;

  // driver model state
  int ds = 0, dcnt = 0, stuck = 0;
  bit early_en = 1'b0;
  bit seen_draw = 1'b0;
  logic [6:0] drawn[$];

  always #5 clk = ~clk;

  oled_frame_arbiter #(.FCLK(FCLK), .BUSY_TIMEOUT_MS(BMS)) dut (
    .clk(clk), .rst(rst),
    .iReqA(iReqA), .iFrameA(iFrameA), .oAckA(oAckA),
    .iReqB(iReqB), .iFrameB(iFrameB), .oAckB(oAckB),
    .oPlaceHolder(oPlaceHolder), .oChar(oChar), .oDraw(oDraw), .iBusy(iBusy),
    .oActive(oActive), .oOwner(oOwner), .oTimeout(oTimeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the inputs seen at this edge, compare, drive.
  task automatic step();
    bit eA, eB, eT;
    @(posedge clk);
    #1;
    eA = 1'b0; eB = 1'b0; eT = 1'b0;
    if (!rst) begin
      m_owner = 1'b1; m_idle = 1'b1; m_active = 1'b0; m_draw = 1'b0;
      m_in = 1'b0; m_hi = 1'b0; m_due = 1'b0; m_ack_pend = 1'b0;
      m_idx = 2'd0; m_ph = 2'd0; m_chr = 5'd0; m_shadow = 20'd0;
    end else if (m_ack_pend) begin
      if (m_owner) eB = 1'b1; else eA = 1'b1;
      m_active = 1'b0; m_ack_pend = 1'b0; m_idle = 1'b1;
    end else if (m_due) begin
      m_draw = 1'b1; m_ph = m_idx;
      m_chr = 5'((m_shadow >> (5 * (3 - int'(m_idx)))) & 20'h1f);
      m_in = 1'b1; m_wc = 0; m_hi = 1'b0; m_due = 1'b0;
    end else if (m_in) begin
      m_wc++;
      if (!m_hi && iBusy) begin
        m_hi = 1'b1; m_draw = 1'b0;
      end else if (m_hi && !iBusy) begin
        m_in = 1'b0;
        if (m_idx == 2'd3) m_ack_pend = 1'b1;
        else begin m_idx = m_idx + 2'd1; m_due = 1'b1; end
      end else if (m_wc >= LIMIT) begin
        m_draw = 1'b0; m_in = 1'b0; m_active = 1'b0; m_idle = 1'b1; eT = 1'b1;
        if (m_owner) eB = 1'b1; else eA = 1'b1;
      end
    end else if (m_idle && (iReqA || iReqB)) begin
      if (iReqA && iReqB) m_owner = !m_owner;
      else m_owner = iReqB;
      m_shadow = m_owner ? iFrameB : iFrameA;
      m_idx = 2'd0; m_active = 1'b1; m_due = 1'b1; m_idle = 1'b0;
    end

    chk("active",  32'(oActive),      32'(m_active));
    chk("owner",   32'(oOwner),       32'(m_owner));
    chk("draw",    32'(oDraw),        32'(m_draw));
    chk("ph_idx",  32'(oPlaceHolder), 32'(m_ph));
    chk("char",    32'(oChar),        32'(m_chr));
    chk("ackA",    32'(oAckA),        32'(eA));
    chk("ackB",    32'(oAckB),        32'(eB));
    chk("timeout", 32'(oTimeout),     32'(eT));

    if (oDraw && !seen_draw) drawn.push_back({oPlaceHolder, oChar});
    seen_draw = oDraw;

    if (stuck == 1) iBusy = 1'b0;
    else if (stuck == 2) iBusy = 1'b1;
    else begin
      case (ds)
        0: if (oDraw) begin dcnt = int'($urandom_range(0, 3)); ds = 1; end
        1: if (dcnt == 0) begin iBusy = 1'b1; dcnt = int'($urandom_range(1, 6)); ds = 2; end
           else dcnt--;
        2: if (dcnt <= 1) begin iBusy = 1'b0; ds = 3; end
           else dcnt--;
        3: if (early_en && $urandom_range(0, 2) == 0) begin iBusy = 1'b1; dcnt = 6; ds = 4; end
           else ds = 0;
        default: if (oDraw) begin dcnt = int'($urandom_range(1, 5)); ds = 2; end
                 else if (dcnt == 0) begin iBusy = 1'b0; ds = 0; end
                 else dcnt--;
      endcase
    end
  endtask

  initial begin
    int n;
    logic [3:0] ord;
    int acks;

    // reset state
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();

    // single client A
    drawn.delete();
    iFrameA = {5'd1, 5'd2, 5'd3, 5'd4};
    iReqA = 1'b1;
    n = 0;
    while (!oAckA && n < 300) begin step(); n++; end
    chk("single_wait", 32'(n < 300), 32'd1);
    iReqA = 1'b0;
    chk("single_count", 32'(drawn.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < drawn.size()) chk("single_draw", 32'(drawn[i]), 32'(i * 32 + i + 1));
    for (int i = 0; i < 5; i++) step();

    // tie after reset, frames changing underneath
    rst = 1'b0; step(); rst = 1'b1;
    iReqA = 1'b1; iReqB = 1'b1;
    ord = 4'd0; acks = 0; n = 0;
    while (acks < 4 && n < 800) begin
      iFrameA = 20'($urandom);
      iFrameB = ($urandom_range(0, 1) == 0) ? {4{5'd16}} : 20'($urandom);
      step(); n++;
      if (oAckA || oAckB) begin ord = {ord[2:0], oAckB}; acks++; end
    end
    iReqA = 1'b0; iReqB = 1'b0;
    chk("tie_order", 32'(ord), 32'(4'b0101));
    for (int i = 0; i < 5; i++) step();

    // busy stuck low after the second draw
    iFrameA = 20'($urandom);
    iReqA = 1'b1;
    n = 0;
    while (!(oDraw && oPlaceHolder == 2'd1) && n < 300) begin step(); n++; end
    chk("to_wait_ph1", 32'(n < 300), 32'd1);
    stuck = 1; iBusy = 1'b0;
    n = 1;
    for (int i = 0; i < 60 && !oTimeout; i++) begin
      step();
      if (oDraw) n++;
    end
    chk("to_pulse", 32'(oTimeout), 32'd1);
    chk("to_draw_len", 32'(n), 32'(LIMIT));
    iReqA = 1'b0; stuck = 0; ds = 0;
    for (int i = 0; i < 5; i++) step();

    // busy stuck high, client B
    iFrameB = 20'($urandom);
    iReqB = 1'b1;
    n = 0;
    while (!oDraw && n < 100) begin step(); n++; end
    chk("toB_wait", 32'(n < 100), 32'd1);
    stuck = 2; iBusy = 1'b1;
    n = 0;
    while (!oTimeout && n < 60) begin step(); n++; end
    chk("toB_ack", 32'(oAckB), 32'd1);
    iReqB = 1'b0; stuck = 0; iBusy = 1'b0; ds = 0;
    for (int i = 0; i < 5; i++) step();

    // reset in WAIT_LO of char 2 with both clients requesting
    iReqA = 1'b1; iReqB = 1'b1;
    n = 0;
    while (!(oDraw && oPlaceHolder == 2'd2) && n < 300) begin step(); n++; end
    chk("rst_wait_ph2", 32'(n < 300), 32'd1);
    stuck = 2; iBusy = 1'b1;
    step(); step();
    rst = 1'b0; step();
    rst = 1'b1; stuck = 0; iBusy = 1'b0; ds = 0;
    n = 0;
    while (!oActive && n < 20) begin step(); n++; end
    chk("rst_grantA", 32'(oOwner), 32'd0);
    iReqA = 1'b0; iReqB = 1'b0;
    n = 0;
    while (oActive && n < 300) begin step(); n++; end
    chk("rst_drain", 32'(n < 300), 32'd1);

    // randomized traffic with early busy and rare resets
    early_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) iReqA = ~iReqA;
      if ($urandom_range(0, 7) == 0) iReqB = ~iReqB;
      if ($urandom_range(0, 3) == 0) iFrameA = 20'($urandom);
      if ($urandom_range(0, 3) == 0) iFrameB = 20'($urandom);
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1; iReqA = 1'b0; iReqB = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
